// File: rtl/mlp_layer_mem.sv
// mlp_layer_mem: weight/activation store serving layer reads, capturing neuron results, presenting the final vector.
// Ports: clk/nrst (async active-low); in_valid/x_in start an inference; wload_* write one weight row;
// read_en/layer_addr -> rd_valid/w_out/act_out one cycle later; write_en/res_in capture results when pending;
// done -> y_out/y_valid; err is sticky until in_valid or reset.
module mlp_layer_mem #(
  parameter int M = 3,
  parameter int N = 2,
  parameter int W = 8,
  parameter int ADDR_W = (M > 2) ? $clog2(M - 1) : 1,
  parameter int NSEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                in_valid,
  input  logic [N*W-1:0]      x_in,
  input  logic                wload_en,
  input  logic [ADDR_W-1:0]   wload_layer,
  input  logic [NSEL_W-1:0]   wload_neuron,
  input  logic [N*W-1:0]      wload_data,
  input  logic                read_en,
  input  logic [ADDR_W-1:0]   layer_addr,
  input  logic                write_en,
  input  logic [N*W-1:0]      res_in,
  input  logic                done,
  output logic                rd_valid,
  output logic [N*N*W-1:0]    w_out,
  output logic [N*W-1:0]      act_out,
  output logic [N*W-1:0]      y_out,
  output logic                y_valid,
  output logic                err
);
  logic [N*W-1:0] wmem [M-1][N];
  logic [N*W-1:0] act_reg;
  logic [N*W-1:0] act_src;
  logic           pending;
  logic           rd_req;
  logic           rd_ok;
  logic           rd_bad;
  logic           wr_acc;
  logic           overrun;
  logic           wl_bad;
  logic           dn;
  always_comb begin
    rd_req  = read_en & ~in_valid;
    rd_ok   = rd_req & (int'(layer_addr) <= M - 2);
    rd_bad  = rd_req & (int'(layer_addr) > M - 2);
    wr_acc  = write_en & pending & ~in_valid;
    // A read while still waiting on results, with no write landing this edge, loses a layer.
    overrun = rd_req & pending & ~wr_acc;
    wl_bad  = wload_en & ((int'(wload_layer) > M - 2) | (int'(wload_neuron) > N - 1));
    dn      = done & ~in_valid;
    // Forward results written this edge so read+write can run every cycle.
    act_src = wr_acc ? res_in : act_reg;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wmem     <= '{default: '0};
      act_reg  <= '0;
      pending  <= 1'b0;
      rd_valid <= 1'b0;
      w_out    <= '0;
      act_out  <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      y_valid  <= dn;
      if (wload_en && !wl_bad) wmem[wload_layer][wload_neuron] <= wload_data;
      if (rd_ok) begin
        for (int n = 0; n < N; n++) w_out[n*N*W +: N*W] <= wmem[layer_addr][n];
        act_out <= act_src;
      end
      if (dn) y_out <= act_src;
      act_reg <= in_valid ? x_in : act_src;
      pending <= in_valid ? 1'b0 : rd_ok ? 1'b1 : wr_acc ? 1'b0 : pending;
      err     <= (in_valid ? 1'b0 : (err | rd_bad | overrun)) | wl_bad;
    end
  end
endmodule

// File: tb/tb_mlp_layer_mem.sv
// tb_mlp_layer_mem: directed self-checking bench for mlp_layer_mem.
module tb_mlp_layer_mem;
  localparam int M = 3, N = 2, W = 8, ADDR_W = 2, NSEL_W = 1;
  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              in_valid, wload_en, read_en, write_en, done;
  logic [N*W-1:0]    x_in, wload_data, res_in;
  logic [ADDR_W-1:0] wload_layer, layer_addr;
  logic [NSEL_W-1:0] wload_neuron;
  logic              rd_valid, y_valid, err;
  logic [N*N*W-1:0]  w_out;
  logic [N*W-1:0]    act_out, y_out;
  int compared = 0;
  int mismatched = 0;
  mlp_layer_mem #(.M(M), .N(N), .W(W), .ADDR_W(ADDR_W), .NSEL_W(NSEL_W)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .x_in(x_in),
    .wload_en(wload_en), .wload_layer(wload_layer), .wload_neuron(wload_neuron), .wload_data(wload_data),
    .read_en(read_en), .layer_addr(layer_addr), .write_en(write_en), .res_in(res_in), .done(done),
    .rd_valid(rd_valid), .w_out(w_out), .act_out(act_out), .y_out(y_out), .y_valid(y_valid), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid = 0; wload_en = 0; read_en = 0; done = 0;
  endtask
  task automatic wload(input logic [ADDR_W-1:0] l, input logic [NSEL_W-1:0] n, input logic [N*W-1:0] d);
    idle(); wload_en = 1; wload_layer = l; wload_neuron = n; wload_data = d;
    step();
    wload_en = 0;
  endtask
  task automatic load_x(input logic [N*W-1:0] x);
    idle(); in_valid = 1; x_in = x;
    step();
    in_valid = 0;
  endtask
  task automatic rd(input logic [ADDR_W-1:0] l);
    idle(); read_en = 1; layer_addr = l;
    step();
    read_en = 0;
  endtask
  initial begin
    in_valid = $urandom; wload_en = $urandom; read_en = $urandom; write_en = $urandom; done = $urandom;
    x_in = N*W'($urandom); wload_data = N*W'($urandom); res_in = N*W'($urandom);
    wload_layer = ADDR_W'($urandom); wload_neuron = NSEL_W'($urandom); layer_addr = ADDR_W'($urandom);
    step(); step();
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_y_valid", 64'(y_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_w_out", 64'(w_out), 64'd0);
    chk("rst_act_out", 64'(act_out), 64'd0);
    chk("rst_y_out", 64'(y_out), 64'd0);
    idle(); write_en = 0; x_in = '0; res_in = '0; wload_data = '0; wload_layer = '0; wload_neuron = '0; layer_addr = '0;
    nrst = 1;
    wload(0, 0, 16'h0103);
    wload(0, 1, 16'h0402);
    wload(1, 0, 16'h0001);
    wload(1, 1, 16'h0100);
    load_x(16'h0205);
    chk("load_err", 64'(err), 64'd0);
    chk("load_rd_valid", 64'(rd_valid), 64'd0);
    rd(0);
    chk("basic_rd_valid", 64'(rd_valid), 64'd1);
    chk("basic_w_out", 64'(w_out), 64'h04020103);
    chk("basic_act_out", 64'(act_out), 64'h0205);
    write_en = 1; res_in = 16'h0409;
    rd(1);
    chk("chain_rd_valid", 64'(rd_valid), 64'd1);
    chk("chain_act_out", 64'(act_out), 64'h0409);
    chk("chain_w_out", 64'(w_out), 64'h01000001);
    chk("chain_err", 64'(err), 64'd0);
    res_in = 16'h0107; done = 1;
    step();
    done = 0; write_en = 0;
    chk("done_y_out", 64'(y_out), 64'h0107);
    chk("done_y_valid", 64'(y_valid), 64'd1);
    chk("done_rd_valid", 64'(rd_valid), 64'd0);
    step();
    chk("done_y_valid_pulse", 64'(y_valid), 64'd0);
    chk("done_y_out_hold", 64'(y_out), 64'h0107);
    load_x(16'h0205);
    write_en = 1; res_in = 16'hFFFF;
    step(); step();
    chk("idle_wr_err", 64'(err), 64'd0);
    rd(0);
    write_en = 0;
    chk("idle_wr_act_out", 64'(act_out), 64'h0205);
    load_x(16'h0205);
    chk("clear_err", 64'(err), 64'd0);
    rd(2);
    chk("oor_rd_valid", 64'(rd_valid), 64'd0);
    chk("oor_err", 64'(err), 64'd1);
    chk("oor_act_hold", 64'(act_out), 64'h0205);
    chk("oor_w_hold", 64'(w_out), 64'h04020103);
    step();
    chk("oor_err_sticky", 64'(err), 64'd1);
    load_x(16'h0205);
    chk("in_valid_clr_err", 64'(err), 64'd0);
    rd(0);
    chk("ovr_first_err", 64'(err), 64'd0);
    rd(0);
    chk("ovr_rd_valid", 64'(rd_valid), 64'd1);
    chk("ovr_err", 64'(err), 64'd1);
    load_x(16'h0205);
    chk("ovr_clr_err", 64'(err), 64'd0);
    wload(2, 0, 16'hAAAA);
    chk("wl_bad_err", 64'(err), 64'd1);
    rd(0);
    chk("wl_bad_w_unchanged", 64'(w_out), 64'h04020103);
    load_x(16'h0205);
    idle(); read_en = 1; layer_addr = 0; wload_en = 1; wload_layer = 0; wload_neuron = 0; wload_data = 16'h0606;
    step();
    idle();
    chk("rbw_old", 64'(w_out), 64'h04020103);
    rd(0);
    chk("rbw_new", 64'(w_out), 64'h04020606);
    #2 nrst = 0;
    #1;
    chk("arst_rd_valid", 64'(rd_valid), 64'd0);
    chk("arst_w_out", 64'(w_out), 64'd0);
    chk("arst_act_out", 64'(act_out), 64'd0);
    chk("arst_y_out", 64'(y_out), 64'd0);
    step();
    nrst = 1;
    write_en = 1; res_in = 16'h0909;
    step();
    write_en = 0;
    rd(0);
    chk("post_rst_rd_valid", 64'(rd_valid), 64'd1);
    chk("post_rst_act_out", 64'(act_out), 64'd0);
    chk("post_rst_w_out", 64'(w_out), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mlp_layer_mem.md
# mlp_layer_mem

Responder-side storage for the N-neuron MLP datapath: serves the layer controller's `read_en`/`layer_addr` requests with that layer's weight matrix and the current activation vector. It captures the neuron results on `write_en` as the next activation vector and presents the final vector on `done`. It sits between the host (weight and input loading), the layer controller, and the N parallel neuron units.

## Interface
Parameters:
- `M`, default 3: number of layers including input; weight layers are 0..M-2.
- `N`, default 2: neurons per layer; equals the activation vector length.
- `W`, default 8: data width of weights, activations and results.
- `ADDR_W`, default `(M>2) ? $clog2(M-1) : 1`: layer address width.
- `NSEL_W`, default `(N>1) ? $clog2(N) : 1`: neuron select width.

Ports:
- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: load `x_in` as the activation vector and start a new inference.
- `x_in` in N*W: input vector; element i is at bits [i*W +: W].
- `wload_en` in 1: write one weight row.
- `wload_layer` in ADDR_W: layer of the row being written.
- `wload_neuron` in NSEL_W: neuron of the row being written.
- `wload_data` in N*W: weight row; element j is the weight of input j.
- `read_en` in 1: controller read request.
- `layer_addr` in ADDR_W: layer being read.
- `write_en` in 1: controller write strobe; qualified internally.
- `res_in` in N*W: neuron results for the pending layer.
- `done` in 1: controller end-of-inference pulse.
- `rd_valid` out 1: `w_out` and `act_out` valid, one-cycle pulse.
- `w_out` out N*N*W: weight matrix of the read layer; row n is at [n*N*W +: N*W].
- `act_out` out N*W: activation vector for the read layer.
- `y_out` out N*W: final result vector; held until the next `done` or reset.
- `y_valid` out 1: one-cycle pulse when `y_out` updates.
- `err` out 1: sticky protocol error.

## Operation
- Storage:
  - weight register array of (M-1)*N rows of N*W bits;
  - `act_reg` of N*W bits;
  - `pending` flag.
- Reset: weights, `act_reg`, `pending`, and all outputs go to 0.
- Weight load: when `wload_en`, the row (`wload_layer`, `wload_neuron`) takes `wload_data`. If `wload_layer > M-2` or `wload_neuron > N-1`, the write is ignored and `err` is set.
- Input load: on `in_valid`, `act_reg <= x_in`, `pending <= 0`, and `err <= 0`. `in_valid` overrides `read_en`, `write_en` and `done` in the same cycle; those inputs are ignored.
- Write qualification: a write is accepted only when `write_en` and `pending` are both 1.
  - An accepted write does `act_reg <= res_in` and `pending <= 0`.
  - `write_en` with `pending`=0 is ignored without error. The controller holds `write_en` high outside of writes.
- Read, `read_en` with `layer_addr <= M-2`:
  - registers `w_out` with that layer's matrix;
  - registers `act_out` with `act_reg`, or with `res_in` if a write is accepted in the same cycle (forwarding);
  - pulses `rd_valid`;
  - sets `pending <= 1`.
- Out-of-range read, `layer_addr > M-2`: no `rd_valid`, `w_out`/`act_out` hold, `pending` unchanged, `err` set.
- Overrun: `read_en` while `pending`=1 and no write is accepted in the same cycle. The read is still served, and `err` is set.
- Done: on `done`, `y_out` is registered with `act_reg`, or with `res_in` if a write is accepted in the same cycle, and `y_valid` pulses.
- Simultaneous weight write and read of the same row: the read returns the old weight (read-before-write).

## Timing
- Read latency is 1: `read_en` at edge t gives `rd_valid`=1 with data during cycle t+1. Data holds after `rd_valid` falls.
- Writes take effect at the edge where they are sampled. Back-to-back read+write every cycle is supported at full rate via forwarding.
- `y_valid` is high in the cycle after `done` is sampled. `done` held for k cycles gives k pulses.
- `err` goes high in the cycle after the offending edge and stays high until `in_valid` or reset.
- Reset mid-operation: all state clears immediately on `nrst` falling. The first request is honoured at the first rising edge with `nrst`=1.

## Test plan
Default parameters: M=3, N=2, W=8.
- Reset: assert `nrst`=0 for 2 cycles with random inputs -> `rd_valid`, `y_valid` and `err` are 0, and `w_out`, `act_out` and `y_out` are 0.
- Basic read: load layer0 rows n0={3,1} and n1={2,4}, then `in_valid` with x={5,2}; `read_en` with L=0 -> next cycle `rd_valid`=1, `w_out` rows n0={3,1} and n1={2,4}, `act_out`={5,2}.
- Chained inference:
  - read L=0;
  - next cycle, read L=1 with `write_en`, `res_in`={9,4} -> `act_out`={9,4};
  - next cycle, `done` with `write_en`, `res_in`={7,1} -> `y_out`={7,1} and `y_valid` high for one cycle.
- Idle `write_en`: hold `write_en`=1 with `res_in`={0xFF,0xFF} and no read pending -> `act_reg` is unchanged; a later read shows `act_out`={5,2}.
- Errors:
  - `read_en` with L=2 -> no `rd_valid`, `err`=1 and held;
  - two reads without a write -> `err`=1;
  - `wload_layer`=2 -> weights unchanged and `err`=1;
  - `in_valid` -> `err`=0.
- Reset mid-operation: drop `nrst` while `pending`=1 -> outputs are 0 asynchronously; after release, a `write_en` is ignored.
